// File: rtl/mux_arb_nto1.sv
// mux_arb_nto1: N-to-1 channel mux with explicit-select or round-robin arbitration
// feeding a single registered output stage with valid/ready handshake.
module mux_arb_nto1 #(
  parameter int SIZE = 32,
  parameter int CHANNELS = 4,
  parameter int MODE = 0,
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CHANNELS*SIZE-1:0] in_data,
  input  logic [CHANNELS-1:0]      in_valid,
  output logic [CHANNELS-1:0]      in_ready,
  input  logic [SEL_W-1:0]         sel,
  output logic [SIZE-1:0]          out_data,
  output logic [SEL_W-1:0]         out_chan,
  output logic                     out_valid,
  input  logic                     out_ready
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state_q, state_d;
  logic [SIZE-1:0] data_q, data_d, gnt_data;
  logic [SEL_W-1:0] chan_q, chan_d, ptr_q, ptr_d, gnt_i;
  logic gnt_v, load_en, xfer;
  // Candidate order: fixed 0..N-1 for select mode, rotating from ptr for round-robin.
  function automatic int cand(input logic [SEL_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    return (MODE == 1) ? ((s >= CHANNELS) ? s - CHANNELS : s) : k;
  endfunction
  // Matching sel against each legal index keeps an out-of-range sel from indexing past the bus.
  always_comb begin
    gnt_v = 1'b0;
    gnt_i = '0;
    gnt_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!gnt_v && in_valid[cand(ptr_q, k)] && (MODE == 1 || sel == SEL_W'(cand(ptr_q, k)))) begin
        gnt_v = 1'b1;
        gnt_i = SEL_W'(cand(ptr_q, k));
        gnt_data = in_data[cand(ptr_q, k)*SIZE +: SIZE];
      end
    end
  end
  always_comb begin
    load_en = (state_q == EMPTY) || out_ready;
    xfer = load_en && gnt_v;
    in_ready = (xfer && rst_n) ? (CHANNELS'(1) << gnt_i) : '0;
    state_d = load_en ? (gnt_v ? FULL : EMPTY) : state_q;
    data_d = xfer ? gnt_data : data_q;
    chan_d = xfer ? gnt_i : chan_q;
    ptr_d = (MODE == 1 && xfer) ? ((gnt_i == SEL_W'(CHANNELS - 1)) ? '0 : gnt_i + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q <= '0;
      chan_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      chan_q <= chan_d;
      ptr_q <= ptr_d;
    end
  end
  assign out_data = data_q;
  assign out_chan = chan_q;
  assign out_valid = (state_q == FULL);
endmodule

// File: tb/tb_mux_arb_nto1.sv
// tb_mux_arb_nto1: three instances (select C=4, round-robin C=4, select C=3) driven
// one at a time from a vector table plus hand sequences, checked through a scoreboard queue.
module tb_mux_arb_nto1;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [127:0] d [3];
  logic [3:0] v [3];
  logic [1:0] s [3];
  logic r [3];
  logic [3:0] rdy [3];
  logic [2:0] rdy_c;
  logic [31:0] od [3];
  logic [1:0] oc [3];
  logic ov [3];
  int checks = 0;
  int errors = 0;
  logic eov = 1'b0;
  logic [31:0] lastd [3];
  logic [1:0] lastc [3];
  logic [33:0] q [$];
  typedef struct {
    int u;
    logic [1:0] s;
    logic [3:0] v;
    logic r;
    logic [3:0] er;
  } vec_t;
  vec_t tv [$];

  always #5 clk = ~clk;

  mux_arb_nto1 #(.SIZE(32), .CHANNELS(4), .MODE(0)) ua (.clk(clk), .rst_n(rst_n), .in_data(d[0]),
    .in_valid(v[0]), .in_ready(rdy[0]), .sel(s[0]), .out_data(od[0]), .out_chan(oc[0]),
    .out_valid(ov[0]), .out_ready(r[0]));
  mux_arb_nto1 #(.SIZE(32), .CHANNELS(4), .MODE(1)) ub (.clk(clk), .rst_n(rst_n), .in_data(d[1]),
    .in_valid(v[1]), .in_ready(rdy[1]), .sel(s[1]), .out_data(od[1]), .out_chan(oc[1]),
    .out_valid(ov[1]), .out_ready(r[1]));
  mux_arb_nto1 #(.SIZE(32), .CHANNELS(3), .MODE(0)) uc (.clk(clk), .rst_n(rst_n), .in_data(d[2][95:0]),
    .in_valid(v[2][2:0]), .in_ready(rdy_c), .sel(s[2]), .out_data(od[2]), .out_chan(oc[2]),
    .out_valid(ov[2]), .out_ready(r[2]));
  assign rdy[2] = {1'b0, rdy_c};

  task automatic ck(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic add(input int u, input logic [1:0] sl, input logic [3:0] vl, input logic rd, input logic [3:0] er);
    vec_t t;
    t.u = u; t.s = sl; t.v = vl; t.r = rd; t.er = er;
    tv.push_back(t);
  endtask

  task automatic cyc(input int u, input logic [1:0] sl, input logic [3:0] vl, input logic rd,
                     input logic [3:0] er, input logic [127:0] dat);
    logic [1:0] c;
    logic [31:0] w;
    s[u] = sl; v[u] = vl; r[u] = rd; d[u] = dat;
    #1 ck($sformatf("in_ready[%0d]", u), 64'(rdy[u]), 64'(er));
    if (eov && rd && q.size() > 0) void'(q.pop_front());
    c = er[3] ? 2'd3 : er[2] ? 2'd2 : er[1] ? 2'd1 : 2'd0;
    w = dat[c*32 +: 32];
    if (!eov || rd) eov = (er != 4'd0);
    if (er != 4'd0) q.push_back({c, w});
    @(negedge clk);
    ck($sformatf("out_valid[%0d]", u), 64'(ov[u]), 64'(eov));
    if (eov && q.size() == 0) ck("scoreboard_empty", 64'(q.size()), 64'd1);
    else if (eov) begin
      ck($sformatf("out_data[%0d]", u), 64'(od[u]), 64'(q[0][31:0]));
      ck($sformatf("out_chan[%0d]", u), 64'(oc[u]), 64'(q[0][33:32]));
      lastd[u] = q[0][31:0];
      lastc[u] = q[0][33:32];
    end else begin
      ck($sformatf("hold_data[%0d]", u), 64'(od[u]), 64'(lastd[u]));
      ck($sformatf("hold_chan[%0d]", u), 64'(oc[u]), 64'(lastc[u]));
    end
  endtask

  task automatic rnd(output logic [127:0] x);
    x = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) begin v[i] = 4'hF; s[i] = 2'd0; r[i] = 1'b1; end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      ck($sformatf("rst_valid[%0d]", i), 64'(ov[i]), 64'd0);
      ck($sformatf("rst_data[%0d]", i), 64'(od[i]), 64'd0);
      ck($sformatf("rst_chan[%0d]", i), 64'(oc[i]), 64'd0);
      ck($sformatf("rst_ready[%0d]", i), 64'(rdy[i]), 64'd0);
      lastd[i] = '0;
      lastc[i] = '0;
    end
    q.delete();
    eov = 1'b0;
    @(negedge clk);
    ck("rst_hold_valid", 64'(ov[1]), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) v[i] = 4'h0;
  endtask

  initial begin
    logic [127:0] x;
    for (int i = 0; i < 3; i++) begin d[i] = '0; v[i] = '0; s[i] = '0; r[i] = 1'b0; end
    add(0, 2'd1, 4'b0010, 1'b1, 4'b0010);
    add(0, 2'd3, 4'b1111, 1'b1, 4'b1000);
    add(0, 2'd0, 4'b1110, 1'b1, 4'b0000);
    add(0, 2'd0, 4'b0001, 1'b0, 4'b0001);
    add(0, 2'd1, 4'b1111, 1'b0, 4'b0000);
    add(0, 2'd1, 4'b1111, 1'b1, 4'b0010);
    add(0, 2'd0, 4'b0000, 1'b1, 4'b0000);
    add(1, 2'd0, 4'b1111, 1'b1, 4'b0001);
    add(1, 2'd0, 4'b1111, 1'b1, 4'b0010);
    add(1, 2'd0, 4'b1111, 1'b1, 4'b0100);
    add(1, 2'd0, 4'b1111, 1'b1, 4'b1000);
    add(1, 2'd0, 4'b1111, 1'b1, 4'b0001);
    add(1, 2'd0, 4'b1111, 1'b1, 4'b0010);
    add(1, 2'd0, 4'b1111, 1'b0, 4'b0000);
    add(1, 2'd0, 4'b1111, 1'b1, 4'b0100);
    add(1, 2'd0, 4'b0001, 1'b1, 4'b0001);
    add(1, 2'd0, 4'b1001, 1'b1, 4'b1000);
    add(1, 2'd0, 4'b1001, 1'b1, 4'b0001);
    add(1, 2'd0, 4'b1001, 1'b1, 4'b1000);
    add(1, 2'd0, 4'b0000, 1'b1, 4'b0000);
    add(2, 2'd2, 4'b0111, 1'b1, 4'b0100);
    add(2, 2'd3, 4'b0111, 1'b1, 4'b0000);
    add(2, 2'd0, 4'b0111, 1'b1, 4'b0001);
    add(2, 2'd3, 4'b0111, 1'b0, 4'b0000);
    add(2, 2'd3, 4'b0000, 1'b1, 4'b0000);
    @(negedge clk);
    do_reset();
    for (int i = 0; i < tv.size(); i++) begin
      rnd(x);
      cyc(tv[i].u, tv[i].s, tv[i].v, tv[i].r, tv[i].er, x);
    end
    rnd(x);
    x[95:64] = 32'hDEADBEEF;
    cyc(0, 2'd2, 4'b0100, 1'b1, 4'b0100, x);
    rnd(x);
    x[63:32] = 32'h11;
    cyc(0, 2'd1, 4'b0010, 1'b1, 4'b0010, x);
    for (int i = 0; i < 3; i++) begin
      rnd(x);
      cyc(0, 2'(i), 4'b1111, 1'b0, 4'b0000, x);
    end
    rnd(x);
    cyc(0, 2'd3, 4'b1111, 1'b1, 4'b1000, x);
    cyc(0, 2'd0, 4'b0000, 1'b1, 4'b0000, x);
    rnd(x);
    cyc(1, 2'd0, 4'b0001, 1'b1, 4'b0001, x);
    rnd(x);
    cyc(1, 2'd0, 4'b1111, 1'b0, 4'b0000, x);
    do_reset();
    rnd(x);
    cyc(1, 2'd0, 4'b1111, 1'b1, 4'b0001, x);
    cyc(1, 2'd0, 4'b1111, 1'b1, 4'b0010, x);
    cyc(1, 2'd0, 4'b0000, 1'b1, 4'b0000, x);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
